// File: rtl/mips_pkg.sv
// Shared types for the MMIO store path: word/select types and the channel decode helper.
package mips_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [31:0]      word_t;
  typedef logic [SEL_W-1:0] ch_sel_t;

  // One-hot destination mask; broadcast targets every channel.
  function automatic logic [NUM_CH-1:0] sel_decode(ch_sel_t sel, logic bcast);
    logic [NUM_CH-1:0] m;
    m      = '0;
    m[sel] = 1'b1;
    if (bcast) m = '1;
    return m;
  endfunction
endpackage

// File: rtl/demux_8_router_if.sv
// Source-side handshake plus the eight per-channel consumer handshakes of the router.
interface demux_8_router_if #(parameter int WIDTH = 32);
  import mips_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0]              in_data;
  ch_sel_t                       in_select;
  logic                          in_bcast;
  logic [NUM_CH-1:0]             out_valid;
  logic [NUM_CH-1:0]             out_ready;
  logic [NUM_CH-1:0][WIDTH-1:0]  out_data;
  logic                          busy;

  modport master (
    output in_valid, in_data, in_select, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_select, in_bcast, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready; free while empty or draining this cycle.
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             free
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  assign free      = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Load beats drain so a same-cycle drain+refill keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (out_ready && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/demux_8_router.sv
// Routes one word stream to one of eight holding slots, or to all eight at once on broadcast.
module demux_8_router
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  demux_8_router_if.slave  bus
);
  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] load;
  logic              accept;

  // Broadcast is all-or-nothing: every slot must be able to take the word.
  assign bus.in_ready = bus.in_bcast ? (&free) : free[bus.in_select];
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = accept ? sel_decode(bus.in_select, bus.in_bcast) : '0;
  assign bus.busy     = |bus.out_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[g]),
      .load_data (bus.in_data),
      .out_ready (bus.out_ready[g]),
      .out_valid (bus.out_valid[g]),
      .out_data  (bus.out_data[g]),
      .free      (free[g])
    );
  end
endmodule

// File: tb/tb_demux_8_router.sv
// Directed scenarios plus random stress against a per-channel queue model of the router.
module tb_demux_8_router;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  demux_8_router_if #(.WIDTH(32)) bus();
  demux_8_router #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  word_t q[NUM_CH][$];
  word_t last_w[NUM_CH];
  logic  m_acc;
  logic [NUM_CH-1:0] m_take;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model view: a channel holds pending words in a queue; it can take a new word
  // if nothing is pending or the pending word leaves this cycle.
  task automatic model_check();
    logic [NUM_CH-1:0]         ev, fr;
    logic [NUM_CH-1:0][31:0]   ed;
    logic                      er;
    for (int i = 0; i < NUM_CH; i++) begin
      ev[i] = (q[i].size() != 0);
      ed[i] = ev[i] ? q[i][0] : last_w[i];
      fr[i] = !ev[i] || bus.out_ready[i];
    end
    er = bus.in_bcast ? (fr == 8'hFF) : fr[bus.in_select];
    chk("in_ready",  {255'd0, bus.in_ready},   {255'd0, er});
    chk("out_valid", {248'd0, bus.out_valid},  {248'd0, ev});
    chk("out_data",  bus.out_data,             ed);
    chk("busy",      {255'd0, bus.busy},       {255'd0, (ev != 0)});
    m_acc  = bus.in_valid && er;
    m_take = ev & bus.out_ready;
  endtask

  task automatic cycle();
    word_t d;
    logic  b, r;
    ch_sel_t s;
    @(negedge clk);
    model_check();
    d = bus.in_data; b = bus.in_bcast; s = bus.in_select; r = reset;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NUM_CH; i++) begin q[i].delete(); last_w[i] = '0; end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_take[i]) void'(q[i].pop_front());
        if (m_acc && (b || s == ch_sel_t'(i))) begin
          q[i].push_back(d);
          last_w[i] = d;
        end
      end
    end
    #1;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0; bus.in_bcast = 1'b0; bus.out_ready = 8'hFF;
    cycle();
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) last_w[i] = '0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_select = '0;
    bus.in_bcast = 1'b0; bus.out_ready = '0;
    @(posedge clk); #1;
    cycle();
    reset = 1'b0;
    chk("rst_valid", {248'd0, bus.out_valid}, 256'd0);
    chk("rst_busy",  {255'd0, bus.busy},      256'd0);

    // Unicast with stall then release.
    bus.in_valid = 1'b1; bus.in_select = 3'd3; bus.in_data = 32'hDEADBEEF; bus.out_ready = '0;
    #1 chk("uc_ready1", {255'd0, bus.in_ready}, 256'd1);
    cycle();
    chk("uc_valid", {248'd0, bus.out_valid}, 256'h08);
    chk("uc_data3", {224'd0, bus.out_data[3]}, 256'hDEADBEEF);
    bus.in_data = 32'hCAFEF00D;
    #1 chk("uc_stall", {255'd0, bus.in_ready}, 256'd0);
    cycle();
    chk("uc_hold3", {224'd0, bus.out_data[3]}, 256'hDEADBEEF);
    bus.out_ready[3] = 1'b1;
    #1 chk("uc_ready2", {255'd0, bus.in_ready}, 256'd1);
    cycle();
    chk("uc_data3b", {224'd0, bus.out_data[3]}, 256'hCAFEF00D);
    drain();

    // Drain and refill slot 5 in the same cycle.
    bus.in_valid = 1'b1; bus.in_select = 3'd5; bus.in_data = 32'h77; bus.out_ready = '0;
    cycle();
    bus.out_ready[5] = 1'b1; bus.in_data = 32'h1;
    #1 chk("dr_ready", {255'd0, bus.in_ready}, 256'd1);
    cycle();
    chk("dr_valid5", {255'd0, bus.out_valid[5]}, 256'd1);
    chk("dr_data5",  {224'd0, bus.out_data[5]},  256'h1);
    drain();

    // Broadcast blocked by one stalled slot, then released.
    bus.in_valid = 1'b1; bus.in_select = 3'd2; bus.in_data = 32'h22; bus.out_ready = '0;
    cycle();
    bus.in_bcast = 1'b1; bus.in_data = 32'hA5A5A5A5;
    #1 chk("bc_block", {255'd0, bus.in_ready}, 256'd0);
    cycle();
    chk("bc_nochg", {248'd0, bus.out_valid}, 256'h04);
    chk("bc_data2", {224'd0, bus.out_data[2]}, 256'h22);
    bus.out_ready[2] = 1'b1;
    #1 chk("bc_ready", {255'd0, bus.in_ready}, 256'd1);
    cycle();
    chk("bc_valid", {248'd0, bus.out_valid}, 256'hFF);
    chk("bc_data", bus.out_data, {8{32'hA5A5A5A5}});
    drain();

    // Independence: slot 0 drains while slot 4 loads, slot 7 untouched.
    bus.in_valid = 1'b1; bus.out_ready = '0;
    bus.in_select = 3'd0; bus.in_data = 32'h100; cycle();
    bus.in_select = 3'd7; bus.in_data = 32'h700; cycle();
    bus.in_select = 3'd4; bus.in_data = 32'h400; bus.out_ready = 8'h01;
    cycle();
    chk("ind_valid", {248'd0, bus.out_valid}, 256'h90);
    chk("ind_data7", {224'd0, bus.out_data[7]}, 256'h700);
    chk("ind_data4", {224'd0, bus.out_data[4]}, 256'h400);
    drain();

    // Reset mid-operation with a pending accept.
    bus.in_valid = 1'b1; bus.out_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.in_select = ch_sel_t'(i); bus.in_data = 32'h1000 + i; cycle();
    end
    chk("rm_full", {248'd0, bus.out_valid}, 256'hFF);
    reset = 1'b1; bus.in_bcast = 1'b1; bus.out_ready = 8'hFF;
    cycle();
    reset = 1'b0; bus.in_valid = 1'b0; bus.in_bcast = 1'b0; bus.out_ready = '0;
    chk("rm_valid", {248'd0, bus.out_valid}, 256'd0);
    chk("rm_data",  bus.out_data, 256'd0);
    chk("rm_busy",  {255'd0, bus.busy}, 256'd0);

    // Random stress.
    for (int n = 0; n < 10000; n++) begin
      reset         = ($urandom_range(0, 499) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_bcast  = ($urandom_range(0, 7) == 0);
      bus.in_select = ch_sel_t'($urandom_range(0, 7));
      bus.in_data   = $urandom;
      bus.out_ready = 8'($urandom) & 8'($urandom | $urandom);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
